// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage of the pipelined OTTER core. This block holds the PC register and
//   handles one instruction-memory request at a time. It has a one-entry hold
//   buffer for a word that arrives while ID is stalled, and it drives the IF/ID
//   pipeline register.
//
// Parameters
//   RESET_PC      first PC fetched after reset
//   NOP_INSTR     instruction word placed in IF/ID when it holds a bubble
//
// Ports
//   CLK, RST_N    clock (posedge) and asynchronous active-low reset
//   PCWrite       hazard detector: PC may advance
//   IF_ID_Write   hazard detector: IF/ID may load
//   flush         EX redirect pulse; branch_target is the new PC (low bits ignored)
//   imem_req/addr fetch request and word-aligned address, stable until ready
//   imem_ready    memory accepts the request; imem_rdata is valid this cycle
//   imem_rdata    fetched instruction
//   if_id_*       IF/ID register: pc, pc+4, instruction, valid (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        advance;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ld;
  logic [31:0] ld_instr;

  assign advance  = PCWrite & IF_ID_Write;
  assign target   = branch_target & ~32'h0000_0003;
  assign pc_plus4 = pc_q + 32'd4;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      redir_q      <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      redir_q      <= redir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    redir_d      = redir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    ld           = 1'b0;
    ld_instr     = imem_rdata;

    unique case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          if (flush) begin
            pc_d = target;
          end else if (advance) begin
            ld   = 1'b1;
            pc_d = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          // Address must stay stable until the pending transfer completes.
          redir_d = target;
          state_d = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (advance) begin
          ld       = 1'b1;
          ld_instr = hold_q;
          pc_d     = pc_plus4;
          state_d  = S_REQ;
        end
      end
      S_DISCARD: begin
        if (flush) redir_d = target;
        if (imem_ready) begin
          pc_d    = flush ? target : redir_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Flush always bubbles IF/ID; an advance with nothing to load also bubbles.
    // Bubbles keep the old pc fields.
    if (flush || (advance && !ld)) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (ld) begin
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = ld_instr;
      ifid_valid_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    imem_req    = RST_N && (state_q != S_HOLD);
    imem_addr   = pc_q;
    if_id_pc    = ifid_pc_q;
    if_id_pc4   = ifid_pc4_q;
    if_id_instr = ifid_instr_q;
    if_id_valid = ifid_valid_q;
  end

endmodule
